// File: rtl/mem_bus_arb_pkg.sv
// Shared state encoding and default bus widths for the two-master memory bus arbiter.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant decision: a lone requester wins outright, and on a tie
// the master that did not win last time is granted. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_win,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_win ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory slave port; one transaction in flight at a time.
// Define MEM_BUS_ARB_PERF_EN to add the per-master grant counters gnt_cnt0 / gnt_cnt1.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clock,
    input  logic                reset,
`ifdef MEM_BUS_ARB_PERF_EN
    output logic [31:0]         gnt_cnt0,
    output logic [31:0]         gnt_cnt1,
`endif
    input  logic                m0_ren,
    input  logic [ADDR_W-1:0]   m0_raddr,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m0_wen,
    input  logic [ADDR_W-1:0]   m0_waddr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_wready,
    input  logic                m1_ren,
    input  logic [ADDR_W-1:0]   m1_raddr,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    input  logic                m1_wen,
    input  logic [ADDR_W-1:0]   m1_waddr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_wready,
    output logic                s_ren,
    output logic [ADDR_W-1:0]   s_raddr,
    output logic                s_wen,
    output logic [ADDR_W-1:0]   s_waddr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_wready
);

    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_win, last_win_nxt;
    logic [1:0] req;
    logic [1:0] gnt;

    assign req = {m1_ren | m1_wen, m0_ren | m0_wen};

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_win (last_win),
        .gnt      (gnt)
    );

    // last_win resets to 1 so that m0 takes the first tie
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_win <= 1'b1;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_win <= last_win_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_win_nxt = last_win;
        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_nxt    = gnt[1];
                    last_win_nxt = gnt[1];
                    state_nxt    = (gnt[1] ? m1_ren : m0_ren) ? RD : WR;
                end
            end
            RD:      if (s_rvalid) state_nxt = IDLE;
            WR:      if (s_wready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slave request mirrors the owner; responses go back to the owner only and only for
    // the matching transfer type, so stray or wrong-type responses never reach a master.
    always_comb begin
        s_ren     = 1'b0;
        s_raddr   = '0;
        s_wen     = 1'b0;
        s_waddr   = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        m0_rvalid = 1'b0;
        m0_rdata  = '0;
        m0_wready = 1'b0;
        m1_rvalid = 1'b0;
        m1_rdata  = '0;
        m1_wready = 1'b0;
        if (state == RD) begin
            s_ren   = owner ? m1_ren   : m0_ren;
            s_raddr = owner ? m1_raddr : m0_raddr;
            if (owner) begin
                m1_rvalid = s_rvalid;
                m1_rdata  = s_rdata;
            end else begin
                m0_rvalid = s_rvalid;
                m0_rdata  = s_rdata;
            end
        end
        if (state == WR) begin
            s_wen   = owner ? m1_wen   : m0_wen;
            s_waddr = owner ? m1_waddr : m0_waddr;
            s_wdata = owner ? m1_wdata : m0_wdata;
            s_wstrb = owner ? m1_wstrb : m0_wstrb;
            if (owner) m1_wready = s_wready;
            else       m0_wready = s_wready;
        end
    end

`ifdef MEM_BUS_ARB_PERF_EN
    logic grant_fire;
    assign grant_fire = (state == IDLE) && (gnt != 2'b00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (grant_fire) begin
            if (gnt[0]) gnt_cnt0 <= gnt_cnt0 + 32'd1;
            else        gnt_cnt1 <= gnt_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized two-master traffic
// against a queue scoreboard and a round-robin grant model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] data;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_ren, m0_wen, m0_rvalid, m0_wready;
    logic          m1_ren, m1_wen, m1_rvalid, m1_wready;
    logic [AW-1:0] m0_raddr, m0_waddr, m1_raddr, m1_waddr;
    logic [DW-1:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic          s_ren, s_wen, s_rvalid, s_wready;
    logic [AW-1:0] s_raddr, s_waddr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;
`ifdef MEM_BUS_ARB_PERF_EN
    logic [31:0]   gnt_cnt0, gnt_cnt1;
`endif

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
`ifdef MEM_BUS_ARB_PERF_EN
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .m0_ren    (m0_ren),    .m0_raddr (m0_raddr), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
        .m0_wen    (m0_wen),    .m0_waddr (m0_waddr), .m0_wdata  (m0_wdata),  .m0_wstrb (m0_wstrb),
        .m0_wready (m0_wready),
        .m1_ren    (m1_ren),    .m1_raddr (m1_raddr), .m1_rvalid (m1_rvalid), .m1_rdata (m1_rdata),
        .m1_wen    (m1_wen),    .m1_waddr (m1_waddr), .m1_wdata  (m1_wdata),  .m1_wstrb (m1_wstrb),
        .m1_wready (m1_wready),
        .s_ren     (s_ren),     .s_raddr  (s_raddr),  .s_wen     (s_wen),     .s_waddr  (s_waddr),
        .s_wdata   (s_wdata),   .s_wstrb  (s_wstrb),  .s_rvalid  (s_rvalid),  .s_rdata  (s_rdata),
        .s_wready  (s_wready)
    );

    always #5 clock = ~clock;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    // slave behaviour knobs, written only by the main sequence
    int            sl_lat = -1;
    bit            sl_fix_en = 1'b0;
    logic [DW-1:0] sl_fix_data = '0;
    int            stray_req = 0;

    // reference model state
    bit         busy = 1'b0;
    bit         resp_prev = 1'b0;
    bit         last_model = 1'b1;
    logic [1:0] req_prev = 2'b00;
    int         g_cnt0 = 0;
    int         g_cnt1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    task automatic resp_check(input int id, input logic rv, input logic wr, input logic [DW-1:0] rd);
        exp_t e;
        int   sz;
        if (!(rv || wr)) return;
        sz = (id == 0) ? q0.size() : q1.size();
        n_chk++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL resp_m%0d: got rvalid=%0b wready=%0b, expected no response", id, rv, wr);
            return;
        end
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("resp_kind_m%0d", id), {rv, wr}, e.is_rd ? 2'b10 : 2'b01);
        if (e.is_rd) check($sformatf("resp_rdata_m%0d", id), rd, e.data);
    endtask

    task automatic grant_check(input bit win);
        logic          ren, wen;
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        logic [SW-1:0] ws;
        ren = win ? m1_ren   : m0_ren;
        wen = win ? m1_wen   : m0_wen;
        ra  = win ? m1_raddr : m0_raddr;
        wa  = win ? m1_waddr : m0_waddr;
        wd  = win ? m1_wdata : m0_wdata;
        ws  = win ? m1_wstrb : m0_wstrb;
        check($sformatf("gnt_s_ren_m%0d", win), s_ren, ren);
        check($sformatf("gnt_s_wen_m%0d", win), s_wen, wen & ~ren);
        if (ren) begin
            check("gnt_s_raddr", s_raddr, ra);
        end else begin
            check("gnt_s_waddr", s_waddr, wa);
            check("gnt_s_wdata", s_wdata, wd);
            check("gnt_s_wstrb", s_wstrb, ws);
        end
    endtask

    // Monitor: response scoreboard plus grant-order / grant-latency model.
    initial begin
        bit win;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy = 1'b0; resp_prev = 1'b0; last_model = 1'b1; req_prev = 2'b00;
                g_cnt0 = 0; g_cnt1 = 0;
            end else begin
                resp_check(0, m0_rvalid, m0_wready, m0_rdata);
                resp_check(1, m1_rvalid, m1_wready, m1_rdata);
                if (!busy) begin
                    check("grant_timing", s_ren | s_wen, !resp_prev && (req_prev != 2'b00));
                    if (s_ren || s_wen) begin
                        win = (req_prev == 2'b11) ? !last_model : req_prev[1];
                        last_model = win;
                        busy = 1'b1;
                        if (win) g_cnt1++; else g_cnt0++;
                        grant_check(win);
                    end
                end
                resp_prev = busy && ((s_ren && s_rvalid) || (s_wen && s_wready));
                if (resp_prev) busy = 1'b0;
                req_prev = {m1_ren | m1_wen, m0_ren | m0_wen};
            end
        end
    end

    // Slave responder with random latency, wrong-type pulses while busy and stray pulses when idle.
    initial begin
        int cnt = -1;
        int stray_done = 0;
        bit resp_last = 1'b0;
        s_rvalid = 1'b0; s_wready = 1'b0; s_rdata = '0;
        forever begin
            @(posedge clock); #2;
            s_rvalid = 1'b0; s_wready = 1'b0; s_rdata = $urandom;
            if (reset) begin
                cnt = -1; resp_last = 1'b0;
            end else if (s_ren || s_wen) begin
                if (cnt < 0) cnt = (sl_lat >= 0) ? sl_lat : $urandom_range(0, 3);
                if (cnt == 0) begin
                    if (s_ren) begin
                        s_rvalid = 1'b1;
                        s_rdata  = sl_fix_en ? sl_fix_data : rd_fn(s_raddr);
                    end else begin
                        s_wready = 1'b1;
                    end
                    cnt = -1; resp_last = 1'b1;
                end else begin
                    cnt--; resp_last = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin
                        if (s_ren) s_wready = 1'b1; else s_rvalid = 1'b1;
                    end
                end
            end else begin
                if (stray_done != stray_req || (resp_last && $urandom_range(0, 1) == 1)) begin
                    s_rvalid = 1'b1; s_wready = 1'b1; stray_done = stray_req;
                end
                resp_last = 1'b0;
            end
        end
    end

    task automatic drive(input int id, input bit rd, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (id == 0) begin
            m0_ren = rd; m0_wen = wr; m0_raddr = a; m0_waddr = a; m0_wdata = d; m0_wstrb = s;
        end else begin
            m1_ren = rd; m1_wen = wr; m1_raddr = a; m1_waddr = a; m1_wdata = d; m1_wstrb = s;
        end
    endtask

    function automatic bit got(input int id);
        return (id == 0) ? (m0_rvalid | m0_wready) : (m1_rvalid | m1_wready);
    endfunction

    task automatic master_run(input int id, input int n);
        bit            rd;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
        for (int k = 0; k < n; k++) begin
            if (k >= 4) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            rd = (k == 0) ? (id == 0) : bit'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            if (id == 0) q0.push_back('{rd, rd ? rd_fn(a) : '0});
            else         q1.push_back('{rd, rd ? rd_fn(a) : '0});
            drive(id, rd, !rd, a, d, SW'($urandom_range(0, 15)));
            cyc = 0;
            do begin
                @(negedge clock);
                cyc++;
            end while (!got(id) && cyc < 60);
            if (!got(id)) begin
                n_chk++; n_fail++;
                $display("FAIL timeout_m%0d: no response after %0d cycles, expected one", id, cyc);
            end
            @(posedge clock); #1;
            drive(id, 1'b0, 1'b0, '0, '0, '0);
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h55, 32'hA5A5A5A5, 4'hF);
        drive(1, 1'b0, 1'b0, 32'h77, 32'h5A5A5A5A, 4'hC);
        repeat (2) @(negedge clock);
        check("rst_s_ren",   s_ren, 1'b0);
        check("rst_s_wen",   s_wen, 1'b0);
        check("rst_s_raddr", s_raddr, '0);
        check("rst_s_wdata", s_wdata, '0);
        check("rst_s_wstrb", s_wstrb, '0);
        check("rst_resp",    {m0_rvalid, m1_rvalid, m0_wready, m1_wready}, 4'b0000);
        @(posedge clock); #1;
        reset = 1'b0;

        // single m0 read with a 3-cycle slave latency
        @(posedge clock); #1;
        sl_lat = 3; sl_fix_en = 1'b1; sl_fix_data = 32'hDEADBEEF;
        q0.push_back('{1'b1, 32'hDEADBEEF});
        m0_ren = 1'b1; m0_raddr = 32'h100;
        @(negedge clock);
        check("d030_s_ren_before", s_ren, 1'b0);
        @(negedge clock);
        check("d030_s_ren_after", s_ren, 1'b1);
        check("d030_s_raddr", s_raddr, 32'h100);
        cyc = 0;
        while (!m0_rvalid && cyc < 20) begin @(negedge clock); cyc++; end
        check("d030_rvalid_delay", cyc, 3);
        check("d030_m1_rvalid", m1_rvalid, 1'b0);
        @(posedge clock); #1;
        m0_ren = 1'b0; sl_fix_en = 1'b0; sl_lat = -1;
        @(negedge clock);
        check("d030_single_pulse", m0_rvalid, 1'b0);

        // m1 write with partial strobes
        @(posedge clock); #1;
        q1.push_back('{1'b0, '0});
        m1_wen = 1'b1; m1_waddr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
        cyc = 0;
        do begin @(negedge clock); cyc++; end while (!s_wen && cyc < 10);
        check("d033_s_wen",   s_wen, 1'b1);
        check("d033_s_ren",   s_ren, 1'b0);
        check("d033_s_waddr", s_waddr, 32'h200);
        check("d033_s_wdata", s_wdata, 32'h12345678);
        check("d033_s_wstrb", s_wstrb, 4'b0011);
        cyc = 0;
        while (!m1_wready && cyc < 20) begin @(negedge clock); cyc++; end
        check("d033_m1_wready", m1_wready, 1'b1);
        check("d033_m0_wready", m0_wready, 1'b0);
        @(posedge clock); #1;
        m1_wen = 1'b0;

        // reset in the middle of a read, then a stray s_rvalid in IDLE
        @(posedge clock); #1;
        sl_lat = 20;
        q0.push_back('{1'b1, rd_fn(32'h340)});
        m0_ren = 1'b1; m0_raddr = 32'h340;
        cyc = 0;
        do begin @(negedge clock); cyc++; end while (!s_ren && cyc < 10);
        check("d034_s_ren_up", s_ren, 1'b1);
        @(posedge clock); #3;
        reset = 1'b1;
        q0.delete();
        #1;
        check("d034_abort_s_ren", s_ren, 1'b0);
        check("d034_abort_s_raddr", s_raddr, '0);
        check("d034_abort_m0_rvalid", m0_rvalid, 1'b0);
        m0_ren = 1'b0;
        repeat (2) @(posedge clock); #1;
        reset = 1'b0; sl_lat = -1;
        stray_req++;
        @(negedge clock);
        check("d034_stray_m0_rvalid", m0_rvalid, 1'b0);
        check("d034_stray_m1_rvalid", m1_rvalid, 1'b0);
        check("d034_stray_wready", {m0_wready, m1_wready}, 2'b00);
        @(negedge clock);
        check("d034_idle_after_stray", s_ren | s_wen, 1'b0);

        // randomized traffic: first both start together (m0 read, m1 write), 4 back-to-back each
        @(posedge clock); #1;
        fork
            master_run(0, 44);
            master_run(1, 44);
        join
        repeat (4) @(negedge clock);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);
`ifdef MEM_BUS_ARB_PERF_EN
        check("perf_gnt_cnt0", gnt_cnt0, g_cnt0);
        check("perf_gnt_cnt1", gnt_cnt1, g_cnt1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
